// File: rtl/oci_dct_pkg.sv
// Shared types and default widths for the OCI DCT trace monitor.
// Entry width depends on OCI_DCT_MON_TIMESTAMP_EN (timestamp prepended when defined).
package oci_dct_pkg;

    localparam int DCT_W_DEF = 30;
    localparam int CNT_W_DEF = 4;
    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 16;
    localparam int OVF_W_DEF = 16;

`ifdef OCI_DCT_MON_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } dct_state_e;

    function automatic int entry_w(input int ts_w, input int cnt_w, input int dct_w);
        return cnt_w + dct_w + (TS_EN ? ts_w : 0);
    endfunction

endpackage

// File: rtl/oci_dct_fifo.sv
// Register-array FIFO with combinational read of the head entry (zero when empty).
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module oci_dct_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             empty_next,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d    = count_q + CW'(push_ok) - CW'(pop_ok);
        empty_next = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so no stale trace survives a mid-run reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/oci_dct_monitor.sv
// OCI DCT trace monitor: captures {dct_count, dct_buffer} on count changes into a FIFO.
// Define OCI_DCT_MON_TIMESTAMP_EN to prepend a free-running cycle timestamp to each entry.
module oci_dct_monitor
    import oci_dct_pkg::*;
#(
    parameter int DCT_W = DCT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int OVF_W = OVF_W_DEF,
    parameter int TS_W  = TS_W_DEF,
    localparam int ENTRY_W = entry_w(TS_W, CNT_W, DCT_W),
    localparam int OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DCT_W-1:0]   dct_buffer,
    input  logic [CNT_W-1:0]   dct_count,
    input  logic               capture_en,
    input  logic               test_ending,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [OCC_W-1:0]   entry_cnt,
    output logic [OVF_W-1:0]   overflow_cnt,
    output logic               test_has_ended
);

    dct_state_e         state_q, state_d;
    logic [CNT_W-1:0]   prev_cnt_q, prev_cnt_d;
    logic [OVF_W-1:0]   ovf_q, ovf_d;
    logic [ENTRY_W-1:0] wr_entry;
    logic               cap_event;
    logic               push;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_empty_next;

`ifdef OCI_DCT_MON_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d = ts_q + TS_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wr_entry = {ts_q, dct_count, dct_buffer};
`else
    assign wr_entry = {dct_count, dct_buffer};
`endif

    // prev_cnt tracks the input in every state so re-arming never sees a stale change.
    assign prev_cnt_d = dct_count;
    assign cap_event  = (dct_count != prev_cnt_q) && (dct_count != '0);
    assign push       = cap_event && (state_q == CAPTURE);
    // When full the FIFO is non-empty, so rd_ready alone decides whether a slot frees up.
    assign drop       = push && fifo_full && !rd_ready;

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (test_ending) begin
                    state_d = DRAIN;
                end else if (capture_en) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (test_ending) begin
                    state_d = DRAIN;
                end else if (!capture_en) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (fifo_empty_next) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (drop && (ovf_q != '1)) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            prev_cnt_q <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_cnt_q <= prev_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    oci_dct_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset_n),
        .push       (push),
        .wdata      (wr_entry),
        .pop        (rd_ready),
        .rdata      (rd_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .empty_next (fifo_empty_next),
        .count      (entry_cnt)
    );

    assign rd_valid       = !fifo_empty;
    assign overflow_cnt   = ovf_q;
    assign test_has_ended = (state_q == DONE);

endmodule

// File: tb/tb_oci_dct_monitor.sv
// Scoreboard bench for oci_dct_monitor: stimulus queues expected entries, a monitor checks pops.
module tb_oci_dct_monitor;

    localparam int DCT_W = 30;
    localparam int CNT_W = 4;
    localparam int DEPTH = 16;
    localparam int OVF_W = 16;
    localparam int TS_W  = 16;
`ifdef OCI_DCT_MON_TIMESTAMP_EN
    localparam int ENTRY_W = TS_W + CNT_W + DCT_W;
`else
    localparam int ENTRY_W = CNT_W + DCT_W;
`endif
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic               clk;
    logic               reset_n;
    logic [DCT_W-1:0]   dct_buffer;
    logic [CNT_W-1:0]   dct_count;
    logic               capture_en;
    logic               test_ending;
    logic               rd_ready;
    logic               rd_valid;
    logic [ENTRY_W-1:0] rd_data;
    logic [OCC_W-1:0]   entry_cnt;
    logic [OVF_W-1:0]   overflow_cnt;
    logic               test_has_ended;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ENTRY_W-1:0] exp_q [$];
    logic [ENTRY_W-1:0] exp_e;

    oci_dct_monitor #(
        .DCT_W (DCT_W),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH),
        .OVF_W (OVF_W),
        .TS_W  (TS_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .capture_en     (capture_en),
        .test_ending    (test_ending),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .entry_cnt      (entry_cnt),
        .overflow_cnt   (overflow_cnt),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef OCI_DCT_MON_TIMESTAMP_EN
    logic [TS_W-1:0] tb_cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cyc <= '0;
        else          tb_cyc <= tb_cyc + TS_W'(1);
    end
`endif

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic [CNT_W-1:0] c, input logic [DCT_W-1:0] b);
`ifdef OCI_DCT_MON_TIMESTAMP_EN
        return {tb_cyc, c, b};
`else
        return {c, b};
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, got, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [CNT_W-1:0] c, input logic [DCT_W-1:0] b, input bit expect_write);
        dct_count  = c;
        dct_buffer = b;
        if (expect_write) exp_q.push_back(mk_entry(c, b));
    endtask

    // Monitor: every accepted read must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h required no entry at %0t", rd_data, $time);
            end else begin
                exp_e = exp_q.pop_front();
                chk("pop_data", 64'(rd_data), 64'(exp_e));
            end
        end
    end

    initial begin
        reset_n = 1'b0; capture_en = 1'b0; test_ending = 1'b0; rd_ready = 1'b0;
        dct_count = '0; dct_buffer = '0;
        #3;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_entry_cnt", 64'(entry_cnt), 64'd0);
        chk("rst_overflow", 64'(overflow_cnt), 64'd0);
        chk("rst_ended", 64'(test_has_ended), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // Single capture, then holding the count must not add entries.
        capture_en = 1'b1; tick();
        ev(4'h3, 30'h2AAAAAAA, 1'b1); tick();
        chk("single_valid", 64'(rd_valid), 64'd1);
        chk("single_data", 64'(rd_data), 64'(exp_q[0]));
        for (int i = 0; i < 3; i++) begin
            dct_buffer = 30'h0000_1555 + 30'(i); tick();
            chk("hold_cnt", 64'(entry_cnt), 64'd1);
            chk("hold_data", 64'(rd_data), 64'(exp_q[0]));
        end
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        chk("single_drained", 64'(entry_cnt), 64'd0);
        chk("single_valid_low", 64'(rd_valid), 64'd0);

        // Overflow: 20 events into 16 slots with no reader.
        for (int i = 0; i < 20; i++) begin
            ev(CNT_W'((i % 15) + 1), 30'(32'h0100_0000 + i * 32'h111), i < 16);
            tick();
        end
        chk("ovf_entry_cnt", 64'(entry_cnt), 64'd16);
        chk("ovf_overflow", 64'(overflow_cnt), 64'd4);

        // Full FIFO with same-cycle pop: write accepted, occupancy unchanged.
        ev(4'h9, 30'h00AB_CDEF, 1'b1); rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        chk("fullpop_entry_cnt", 64'(entry_cnt), 64'd16);
        chk("fullpop_overflow", 64'(overflow_cnt), 64'd4);
        rd_ready = 1'b1; repeat (16) tick(); rd_ready = 1'b0;
        chk("drain_entry_cnt", 64'(entry_cnt), 64'd0);
        chk("drain_rd_data", 64'(rd_data), 64'd0);

        // IDLE ignores events and does not count them as overflow.
        capture_en = 1'b0; tick();
        ev(4'h2, 30'h1, 1'b0); tick();
        ev(4'h7, 30'h2, 1'b0); tick();
        chk("idle_entry_cnt", 64'(entry_cnt), 64'd0);
        chk("idle_overflow", 64'(overflow_cnt), 64'd4);

        // End sequence: 5th event coincides with test_ending and is still written.
        capture_en = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            ev(CNT_W'(i + 1), 30'(32'h0200_0000 + i), 1'b1); tick();
        end
        ev(4'h5, 30'h0300_0005, 1'b1); test_ending = 1'b1; tick(); test_ending = 1'b0;
        chk("end_entry_cnt", 64'(entry_cnt), 64'd5);
        chk("end_not_started", 64'(test_has_ended), 64'd0);
        rd_ready = 1'b1; repeat (4) tick();
        chk("end_before_last_pop", 64'(test_has_ended), 64'd0);
        tick();
        chk("end_after_last_pop", 64'(test_has_ended), 64'd1);
        chk("end_empty", 64'(entry_cnt), 64'd0);
        rd_ready = 1'b0;
        ev(4'hB, 30'h0400_0000, 1'b0); tick(); tick();
        chk("done_ignore_cnt", 64'(entry_cnt), 64'd0);
        chk("done_ignore_valid", 64'(rd_valid), 64'd0);
        chk("done_sticky", 64'(test_has_ended), 64'd1);

        // Mid-operation reset while draining three entries.
        reset_n = 1'b0; #2; reset_n = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            ev(CNT_W'(i + 1), 30'(32'h0500_0000 + i), 1'b1); tick();
        end
        test_ending = 1'b1; tick(); test_ending = 1'b0; tick();
        chk("pre_rst_entry_cnt", 64'(entry_cnt), 64'd3);
        #2; reset_n = 1'b0; #1;
        exp_q.delete();
        chk("midrst_rd_valid", 64'(rd_valid), 64'd0);
        chk("midrst_rd_data", 64'(rd_data), 64'd0);
        chk("midrst_entry_cnt", 64'(entry_cnt), 64'd0);
        chk("midrst_overflow", 64'(overflow_cnt), 64'd0);
        chk("midrst_ended", 64'(test_has_ended), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1; capture_en = 1'b0;
        ev(4'h6, 30'h0600_0000, 1'b0); tick();
        chk("postrst_idle_ignore", 64'(entry_cnt), 64'd0);
        capture_en = 1'b1; tick();
        ev(4'hC, 30'h0700_000C, 1'b1); tick();
        chk("postrst_capture", 64'(entry_cnt), 64'd1);

        // Two events three cycles apart (timestamps differ by 3 in the timestamp build).
        ev(4'hD, 30'h0800_000D, 1'b1); tick(); tick(); tick();
        ev(4'hE, 30'h0900_000E, 1'b1); tick();
        chk("ts_pair_cnt", 64'(entry_cnt), 64'd3);
        rd_ready = 1'b1; repeat (4) tick(); rd_ready = 1'b0;
        chk("final_entry_cnt", 64'(entry_cnt), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oci_dct_monitor.md
# oci_dct_monitor

Parametrised successor to the CPU OCI test-bench stub. It turns the on-chip-instrumentation data-capture-trace (DCT) signals into a working trace monitor. Each change of `dct_count` captures the DCT word into an internal FIFO, and the entries are drained through a valid/ready read port. A test-end sequence flushes the FIFO and then reports completion. The block sits beside the CPU OCI in simulation and debug builds and feeds a trace sink or bench scoreboard.

## Interface
- `DCT_W`, default 30: width of `dct_buffer`.
- `CNT_W`, default 4: width of `dct_count`.
- `DEPTH`, default 16: FIFO entries; power of two, 2..256.
- `OVF_W`, default 16: width of the overflow counter.
- `TS_W`, default 16: timestamp width; used only when the timestamp feature is compiled in.
- `clk` in 1: single clock; every register is clocked on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `dct_buffer` in DCT_W: trace data word from the OCI.
- `dct_count` in CNT_W: DCT entry count from the OCI.
- `capture_en` in 1: arms capture.
- `test_ending` in 1: requests the flush and end sequence.
- `rd_ready` in 1: the sink accepts `rd_data` this cycle.
- `rd_valid` out 1: the FIFO is non-empty.
- `rd_data` out ENTRY_W: oldest FIFO entry.
- `entry_cnt` out $clog2(DEPTH+1): current FIFO occupancy.
- `overflow_cnt` out OVF_W: number of events dropped because the FIFO was full.
- `test_has_ended` out 1: sticky flag; high once the flush completes.

## Operation
- **Entry format:** `ENTRY_W = CNT_W + DCT_W`. Entry = {dct_count, dct_buffer}, with `dct_count` in the MSBs.
- **`prev_cnt` register:** width CNT_W, reset 0. It is updated with `dct_count` every cycle in every state, so re-arming capture never produces a stale event.
- **Capture event:** `dct_count != prev_cnt && dct_count != 0`.
- **State machine:** states IDLE, CAPTURE, DRAIN, DONE. Reset state is IDLE.
  - IDLE → CAPTURE when `capture_en` = 1.
  - IDLE → DRAIN when `test_ending` = 1; `test_ending` has priority over `capture_en`.
  - CAPTURE → IDLE when `capture_en` = 0.
  - CAPTURE → DRAIN when `test_ending` = 1; this has priority over the IDLE transition.
  - DRAIN → DONE when the FIFO is empty. An empty FIFO on DRAIN entry reaches DONE on the next cycle.
  - DONE is terminal until reset. `test_has_ended` = (state == DONE).
- **Which events are written:**
  - CAPTURE: events are written.
  - The cycle in which CAPTURE sees `test_ending`: that cycle's event is still written.
  - IDLE, DRAIN, DONE: events are ignored and not counted as overflow.
- **Reads:** reading is permitted in every state. A pop occurs when `rd_valid && rd_ready`.
- **Full FIFO:**
  - Event while full with a same-cycle pop: the write is accepted and occupancy is unchanged.
  - Event while full without a pop: the entry is dropped and `overflow_cnt` increments, saturating at all-ones.
- **Pointers:** read and write pointers wrap modulo DEPTH. `entry_cnt` ranges 0..DEPTH.

## Timing
- **Reset values:** `rd_valid` = 0, `rd_data` = 0, `entry_cnt` = 0, `overflow_cnt` = 0, `test_has_ended` = 0. Pointers, `prev_cnt`, state and timestamp all reset to 0 / IDLE.
- **Capture latency:** an event in cycle N is written at the end of N. `rd_valid` and `rd_data` show it in cycle N+1.
- **Read path:** `rd_data` is a combinational read of the entry at the read pointer, zero when empty. It holds stable while `rd_valid && !rd_ready`.
- **Pop timing:** the pop takes effect at the clock edge. The next entry, or `rd_valid` = 0, appears in the following cycle.
- **Counters:** `entry_cnt` and `overflow_cnt` are registered and update one edge after the event.
- **Completion:** `test_has_ended` rises in the cycle after the last pop of the flush.
- **Mid-operation reset:** asserting `reset_n` low clears the FIFO contents, state and counters immediately, without waiting for a clock edge.

## Configuration
- **Macro `OCI_DCT_MON_TIMESTAMP_EN`.**
- **Defined:**
  - A free-running TS_W cycle counter runs from reset 0 and wraps.
  - ENTRY_W becomes TS_W + CNT_W + DCT_W, and entry = {ts, dct_count, dct_buffer}.
  - `ts` is the counter value in the capture cycle.
- **Undefined:** no counter exists and entries follow the base format above.

## Structure
- **Package `oci_dct_pkg`:** holds the state enum (IDLE, CAPTURE, DRAIN, DONE), the default widths (30, 4, 16) and the ENTRY_W derivation.
- **Sub-module `oci_dct_fifo`:** synchronous register-array FIFO with push/pop, full/empty and count, parametrised on width and depth. The monitor instantiates it once.

## Test plan
- **Single capture:** `capture_en` = 1, `dct_count` 0→3 with `dct_buffer` = 0x2AAAAAAA → `rd_valid` next cycle, `rd_data` = {4'h3, 30'h2AAAAAAA}. Holding `dct_count` at 3 produces no further entries.
- **Overflow with rd_ready = 0:** DEPTH = 16, 20 distinct non-zero count changes → `entry_cnt` = 16, `overflow_cnt` = 4. Draining returns the first 16 entries in order.
- **Simultaneous write and pop when full:** one event plus `rd_ready` = 1 → `entry_cnt` stays 16, `overflow_cnt` unchanged, and the new entry appears last.
- **End sequence:** 5 entries queued, `test_ending` pulse, `rd_ready` = 1 → 5 pops, then `test_has_ended` = 1 the cycle after the last pop. A later `dct_count` change is ignored.
- **Mid-operation reset:** `reset_n` low while DRAIN is active with 3 entries → outputs drop to reset values immediately and state returns to IDLE.
- **Timestamp build, events at cycles 10 and 13 after reset:** with `OCI_DCT_MON_TIMESTAMP_EN` defined, the two entries' timestamps differ by 3. With the macro undefined, `rd_data` width is 34.
